// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg: shared constants and elaboration helpers for fifo_sync_prog.
//   FIFO_MODE_STD / FIFO_MODE_FWFT : values accepted by the FWFT parameter.
//   fifo_depth_ok()                : DEPTH must be a power of two and >= 2.
package fifo_sync_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  function automatic bit fifo_depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// fifo_sync_mem: DEPTH x DATA_WIDTH storage, one synchronous write port and
// one read port. The read port is asynchronous when FWFT selects
// first-word-fall-through, otherwise registered with a read enable and
// reset to zero.
//   clk, rst          : clock, async active-high reset (read register only)
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr      : read enable (registered mode) and read address
//   o_rdata           : read data
module fifo_sync_mem
  import fifo_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FWFT       = FIFO_MODE_STD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // Storage is intentionally not reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Read enable and reset have no role on the combinational read path.
      logic w_unused;
      assign w_unused = i_re ^ rst;
      assign o_rdata  = r_mem[i_raddr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rdata;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
      end
      assign o_rdata = r_rdata;
    end
  endgenerate

endmodule

// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags and selectable standard/FWFT read mode.
//   clk, rst            : clock, async active-high reset
//   wr_en, din          : write request and data (dropped when full)
//   rd_en, dout         : read request / FWFT pop, read data
//   full, empty         : count == DEPTH, count == 0
//   almost_full/empty   : count >= AF_THRESH, count <= AE_THRESH
//   count               : occupancy 0..DEPTH
// Optional macro FIFO_SYNC_ERR_FLAGS_EN adds clr_err, overflow, underflow
// (sticky request-while-full / request-while-empty flags).
module fifo_sync_prog
  import fifo_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  // Derived from DEPTH; not meant to be overridden.
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned FWFT       = FIFO_MODE_STD,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  generate
    if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
      $error("fifo_sync_prog: DEPTH must be a power of two >= 2");
    end
    if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_aw
      $error("fifo_sync_prog: ADDR_WIDTH must equal $clog2(DEPTH)");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
      $error("fifo_sync_prog: AF_THRESH out of range 1..DEPTH-1");
    end
    if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("fifo_sync_prog: AE_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT > FIFO_MODE_FWFT) begin : g_bad_mode
      $error("fifo_sync_prog: FWFT must be 0 or 1");
    end
  endgenerate

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Flags decode the registered count only.
  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CNT_ONE;
      else if (!w_wr_acc && w_rd_acc) r_count <= r_count - CNT_ONE;
    end
  end

  fifo_sync_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FWFT       (FWFT)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (dout)
  );

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign count        = r_count;

`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) r_overflow <= 1'b1;
      else if (clr_err)    r_overflow <= 1'b0;
      if (rd_en && w_empty) r_underflow <= 1'b1;
      else if (clr_err)     r_underflow <= 1'b0;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
module tb_fifo_sync_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // Standard-mode DUT, DEPTH=16
  logic       wr_en, rd_en;
  logic [7:0] din, dout;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic       clr_err, overflow, underflow;
  logic       f_clr_err, f_overflow, f_underflow;
`endif
  // FWFT DUT, DEPTH=4
  logic       f_wr_en, f_rd_en;
  logic [7:0] f_din, f_dout;
  logic       f_full, f_empty, f_af, f_ae;
  logic [2:0] f_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] q[$];

  fifo_sync_prog #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .FWFT       (0),
    .AF_THRESH  (14),
    .AE_THRESH  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    .clr_err      (clr_err),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .count        (count)
  );

  fifo_sync_prog #(
    .DATA_WIDTH (8),
    .DEPTH      (4),
    .FWFT       (1),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) dut_fwft (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (f_wr_en),
    .din          (f_din),
    .rd_en        (f_rd_en),
    .dout         (f_dout),
    .full         (f_full),
    .empty        (f_empty),
    .almost_full  (f_af),
    .almost_empty (f_ae),
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    .clr_err      (f_clr_err),
    .overflow     (f_overflow),
    .underflow    (f_underflow),
`endif
    .count        (f_count)
  );

  // One clock on the standard DUT; the queue models a 16-entry FIFO and
  // decides acceptance from its occupancy before the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      output logic [7:0] exp_d, output bit popped);
    bit wa, ra;
    wa     = w && (q.size() < 16);
    ra     = r && (q.size() > 0);
    popped = ra;
    exp_d  = 8'h00;
    if (ra) exp_d = q.pop_front();
    if (wa) q.push_back(d);
    wr_en = w; din = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af: got %b want 0", almost_full); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
    total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL reset_f_empty: got %b want 1", f_empty); end
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL reset_err: got ovf=%b unf=%b want 0 0", overflow, underflow);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_fill_drain();
    logic [7:0] e;
    bit p;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, e, p);
      total++; if (count !== 5'(i)) begin bad++; $display("FAIL fill_count: got %0d want %0d", count, i); end
      total++; if (almost_full !== (i >= 14)) begin bad++; $display("FAIL fill_af: got %b want %b at %0d", almost_full, (i >= 14), i); end
      total++; if (full !== (i == 16)) begin bad++; $display("FAIL fill_full: got %b want %b at %0d", full, (i == 16), i); end
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, e, p);
      total++; if (!p || dout !== e) begin bad++; $display("FAIL drain_dout: got %h want %h", dout, e); end
    end
    total++; if (empty !== 1'b1 || count !== 5'd0) begin
      bad++; $display("FAIL drain_empty: got empty=%b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_full_simul();
    logic [7:0] e;
    bit p;
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, e, p);
    step(1'b1, 8'hAA, 1'b1, e, p);
    total++; if (count !== 5'd15) begin bad++; $display("FAIL fullrw_count: got %0d want 15", count); end
    total++; if (dout !== 8'h01 || e !== 8'h01) begin bad++; $display("FAIL fullrw_dout: got %h want 01", dout); end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'h00, 1'b1, e, p);
      total++; if (dout !== e) begin bad++; $display("FAIL fullrw_drain: got %h want %h", dout, e); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fullrw_empty: got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    bit p;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, e, p);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h50 + i), 1'b1, e, p);
      total++; if (dout !== e) begin bad++; $display("FAIL wrap_dout: got %h want %h", dout, e); end
      total++; if (count !== 5'd5 || almost_full !== 1'b0 || almost_empty !== 1'b0 || empty !== 1'b0 || full !== 1'b0) begin
        bad++; $display("FAIL wrap_flags: got count=%0d af=%b ae=%b e=%b f=%b want 5 0 0 0 0",
                        count, almost_full, almost_empty, empty, full);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1, e, p);
      total++; if (dout !== e) begin bad++; $display("FAIL wrap_drain: got %h want %h", dout, e); end
    end
  endtask

  task automatic test_fwft();
    f_wr_en = 1'b1; f_din = 8'h5C;
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    total++; if (f_empty !== 1'b0) begin bad++; $display("FAIL fwft_empty: got %b want 0", f_empty); end
    total++; if (f_dout !== 8'h5C) begin bad++; $display("FAIL fwft_dout: got %h want 5c", f_dout); end
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    total++; if (f_empty !== 1'b1 || f_count !== 3'd0) begin
      bad++; $display("FAIL fwft_pop: got empty=%b count=%0d want 1 0", f_empty, f_count);
    end
    for (int i = 0; i < 4; i++) begin
      f_wr_en = 1'b1; f_din = 8'(8'hC0 + i);
      @(posedge clk); #1;
    end
    f_wr_en = 1'b0;
    total++; if (f_full !== 1'b1 || f_af !== 1'b1 || f_ae !== 1'b0) begin
      bad++; $display("FAIL fwft_full: got f=%b af=%b ae=%b want 1 1 0", f_full, f_af, f_ae);
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (f_dout !== 8'(8'hC0 + i)) begin bad++; $display("FAIL fwft_head: got %h want %h", f_dout, 8'(8'hC0 + i)); end
      f_rd_en = 1'b1;
      @(posedge clk); #1;
    end
    f_rd_en = 1'b0;
    total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL fwft_drain: got %b want 1", f_empty); end
  endtask

`ifdef FIFO_SYNC_ERR_FLAGS_EN
  task automatic test_err_flags();
    logic [7:0] e;
    bit p;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, e, p);
    step(1'b1, 8'hEE, 1'b0, e, p);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    step(1'b0, 8'h00, 1'b0, e, p);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_quiet: got %b want 0", underflow); end
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, e, p);
    step(1'b0, 8'h00, 1'b1, e, p);
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_set: got %b want 1", underflow); end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL err_clr: got ovf=%b unf=%b want 0 0", overflow, underflow);
    end
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, e, p);
    clr_err = 1'b1;
    step(1'b1, 8'hEE, 1'b0, e, p);
    clr_err = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, e, p);
  endtask
`endif

  task automatic test_async_reset();
    logic [7:0] e;
    bit p;
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h90 + i), 1'b0, e, p);
    step(1'b0, 8'h00, 1'b1, e, p);
    total++; if (dout !== 8'h90) begin bad++; $display("FAIL arst_pre: got %h want 90", dout); end
    #2 rst = 1'b1;
    #1;
    total++; if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin
      bad++; $display("FAIL arst_flags: got count=%0d e=%b ae=%b want 0 1 1", count, empty, almost_empty);
    end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL arst_dout: got %h want 00", dout); end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h33, 1'b0, e, p);
    step(1'b0, 8'h00, 1'b1, e, p);
    total++; if (!p || dout !== 8'h33) begin bad++; $display("FAIL arst_after: got %h want 33", dout); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL arst_empty: got %b want 1", empty); end
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_din = 8'h00;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    clr_err = 1'b0; f_clr_err = 1'b0;
`endif
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_wrap();
    test_fwft();
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    test_err_flags();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
